// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor (2-bit PHT) plus BTB lookup/update control.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter  int INDEX_WIDTH = 6,
    localparam int TAG_W       = 32 - INDEX_WIDTH - 2,
    localparam int ENTRIES     = 2 ** INDEX_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            pc_i,
    output logic [INDEX_WIDTH-1:0] rd_index_o,
    input  logic                   btb_valid_i,
    input  logic [TAG_W-1:0]       btb_tag_i,
    input  logic [31:0]            btb_target_i,
    output logic                   pred_taken_o,
    output logic [31:0]            next_pc_o,
    input  logic                   upd_valid_i,
    input  logic [31:0]            upd_pc_i,
    input  logic                   upd_taken_i,
    input  logic [31:0]            upd_target_i,
    input  logic                   upd_pred_taken_i,
    input  logic [31:0]            upd_pred_target_i,
    output logic                   mispredict_o,
    output logic [31:0]            redirect_pc_o,
    output logic                   btb_wren_o,
    output logic [INDEX_WIDTH-1:0] btb_wr_index_o,
    output logic [TAG_W-1:0]       btb_wr_tag_o,
    output logic [31:0]            btb_wr_target_o
);

    logic [1:0]             pht_q [ENTRIES];
    logic [1:0]             pht_d [ENTRIES];
    logic                   stage_valid_q, stage_valid_d;
    logic [INDEX_WIDTH-1:0] stage_idx_q, stage_idx_d;
    logic                   stage_taken_q, stage_taken_d;
    logic                   btb_wren_q, btb_wren_d;
    logic [INDEX_WIDTH-1:0] btb_wr_index_q, btb_wr_index_d;
    logic [TAG_W-1:0]       btb_wr_tag_q, btb_wr_tag_d;
    logic [31:0]            btb_wr_target_q, btb_wr_target_d;
    logic [INDEX_WIDTH-1:0] lu_idx, ap_idx;
    logic [1:0]             ap_cnt;
    logic                   hit;

`ifdef BP_GSHARE_EN
    logic [INDEX_WIDTH-1:0] ghr_q, ghr_d;
    assign lu_idx = pc_i[INDEX_WIDTH+1:2] ^ ghr_q;
    assign ap_idx = stage_idx_q ^ ghr_q;
    assign ghr_d  = stage_valid_q ? {ghr_q[INDEX_WIDTH-2:0], stage_taken_q} : ghr_q;
`else
    assign lu_idx = pc_i[INDEX_WIDTH+1:2];
    assign ap_idx = stage_idx_q;
`endif

    assign rd_index_o = pc_i[INDEX_WIDTH+1:2];

    always_comb begin
        hit           = btb_valid_i && (btb_tag_i == pc_i[31:INDEX_WIDTH+2]);
        pred_taken_o  = hit && pht_q[lu_idx][1];
        next_pc_o     = pred_taken_o ? btb_target_i : pc_i + 32'd4;
        mispredict_o  = 1'b0;
        redirect_pc_o = '0;
        if (upd_valid_i) begin
            mispredict_o  = (upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_target_i != upd_pred_target_i));
            redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;
        end
    end

    always_comb begin
        pht_d  = pht_q;
        ap_cnt = pht_q[ap_idx];
        if (stage_valid_q) begin
            if (stage_taken_q && ap_cnt != 2'd3)
                ap_cnt = ap_cnt + 2'd1;
            else if (!stage_taken_q && ap_cnt != 2'd0)
                ap_cnt = ap_cnt - 2'd1;
            pht_d[ap_idx] = ap_cnt;
        end
        stage_valid_d   = upd_valid_i;
        stage_idx_d     = upd_pc_i[INDEX_WIDTH+1:2];
        stage_taken_d   = upd_taken_i;
        // Write ports are loaded alongside the stage so they appear in its apply cycle.
        btb_wren_d      = upd_valid_i && upd_taken_i;
        btb_wr_index_d  = upd_valid_i ? upd_pc_i[INDEX_WIDTH+1:2] : '0;
        btb_wr_tag_d    = upd_valid_i ? upd_pc_i[31:INDEX_WIDTH+2] : '0;
        btb_wr_target_d = upd_valid_i ? upd_target_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
            stage_valid_q   <= 1'b0;
            btb_wren_q      <= 1'b0;
            btb_wr_index_q  <= '0;
            btb_wr_tag_q    <= '0;
            btb_wr_target_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q           <= '0;
`endif
        end else begin
            pht_q           <= pht_d;
            stage_valid_q   <= stage_valid_d;
            btb_wren_q      <= btb_wren_d;
            btb_wr_index_q  <= btb_wr_index_d;
            btb_wr_tag_q    <= btb_wr_tag_d;
            btb_wr_target_q <= btb_wr_target_d;
`ifdef BP_GSHARE_EN
            ghr_q           <= ghr_d;
`endif
        end
        stage_idx_q   <= stage_idx_d;
        stage_taken_q <= stage_taken_d;
    end

    // A pending write is dropped if reset lands in its apply cycle.
    assign btb_wren_o      = btb_wren_q && !rst_i;
    assign btb_wr_index_o  = btb_wr_index_q;
    assign btb_wr_tag_o    = btb_wr_tag_q;
    assign btb_wr_target_o = btb_wr_target_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direction predictor and BTB controller.
- Consumes the BTB read outputs for the current fetch PC, combines them with a table of 2-bit saturating counters (PHT), and produces the predicted next PC.
- Accepts resolved-branch information from EX, flags mispredicts with a redirect PC, and generates the BTB write port signals one cycle later.

Parameters:
- INDEX_WIDTH, 6: PHT/BTB index width. Tables have 2**INDEX_WIDTH entries. TAG_W = 32-INDEX_WIDTH-2.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_i  in  32  current fetch PC.
- rd_index_o  out  INDEX_WIDTH  BTB read index; equals pc_i[INDEX_WIDTH+1:2].
- btb_valid_i  in  1  BTB entry valid.
- btb_tag_i  in  TAG_W  BTB stored tag.
- btb_target_i  in  32  BTB stored target.
- pred_taken_o  out  1  prediction is taken.
- next_pc_o  out  32  predicted next fetch PC.
- upd_valid_i  in  1  EX reports a resolved control-flow instruction this cycle.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  32  actual target.
- upd_pred_taken_i  in  1  prediction made at fetch, carried down the pipeline.
- upd_pred_target_i  in  32  predicted target, carried down the pipeline.
- mispredict_o  out  1  flush request.
- redirect_pc_o  out  32  correct PC after a mispredict.
- btb_wren_o  out  1  BTB write enable.
- btb_wr_index_o  out  INDEX_WIDTH  BTB write index.
- btb_wr_tag_o  out  TAG_W  BTB write tag.
- btb_wr_target_o  out  32  BTB write target.

Behaviour:
- Lookup (combinational, zero latency):
  - hit = btb_valid_i && (btb_tag_i == pc_i[31:INDEX_WIDTH+2]).
  - pred_taken_o = hit && pht[idx][1].
  - next_pc_o = pred_taken_o ? btb_target_i : pc_i+4. Addition wraps mod 2^32.
- Mispredict (combinational, qualified by upd_valid_i):
  - mispredict_o = (upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - When upd_valid_i=0: mispredict_o=0, redirect_pc_o=0.
- Update stage register:
  - On a cycle with upd_valid_i=1, capture {pc, taken, target} into a one-entry stage and set stage_valid.
  - stage_valid clears on a cycle with upd_valid_i=0.
  - The captured update is applied in the following cycle (latency 1).
- Apply cycle (stage_valid=1):
  - PHT entry at the stage index: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - btb_wren_o=1 only if the stage outcome was taken.
  - Write fields: btb_wr_index_o = stage_pc[INDEX_WIDTH+1:2], btb_wr_tag_o = stage_pc[31:INDEX_WIDTH+2], btb_wr_target_o = stage target.
  - BTB write ports are registered outputs, driven from the stage register.
- Write-port idle values: when stage_valid=0, btb_wren_o=0 and all other write ports hold 0.
- Back-to-back updates: updates on consecutive cycles are applied in order, one per cycle; no update is dropped.
- Same-index updates: counter effects are cumulative.
- Lookup/apply collision: a lookup at an index being applied the same cycle sees the pre-update counter value. There is no bypass.
- Reset (sync, any cycle including mid-update):
  - All PHT counters go to 2'b01 (weakly not-taken).
  - stage_valid=0, btb_wren_o=0, write ports=0.
  - Any pending update is discarded.
- While rst_i=1 the combinational outputs still track their inputs, using reset PHT values after the first reset edge.

Optional Feature:
- BP_GSHARE_EN defined:
  - Adds an INDEX_WIDTH-bit global history register (GHR), reset to 0.
  - PHT index for both lookup and apply is pc[INDEX_WIDTH+1:2] XOR GHR.
  - On each apply cycle the GHR shifts left, inserting the stage outcome at bit 0; the PHT update uses the GHR value before the shift.
  - BTB indexing is unaffected.
- BP_GSHARE_EN not defined: bimodal predictor. PHT index = pc[INDEX_WIDTH+1:2]. No GHR is present.

Test Plan:
- Reset, then pc_i=0x100 with btb_valid_i=0 -> pred_taken_o=0, next_pc_o=0x104, btb_wren_o=0.
- Taken update: upd_valid_i=1, upd_pc_i=0x100, upd_taken_i=1, upd_target_i=0x200, upd_pred_taken_i=0 -> same cycle: mispredict_o=1, redirect_pc_o=0x200.
  - Next cycle: btb_wren_o=1, index=0x00, tag=0x000001 (pc[31:8] with INDEX_WIDTH=6), target=0x200.
  - PHT[0] becomes 2.
  - Then with btb_valid_i=1, matching tag, target=0x200 -> pred_taken_o=1, next_pc_o=0x200.
- Saturation: four taken updates at 0x100 -> counter 3. Then one not-taken -> 2, prediction still taken. Second not-taken -> 1, pred_taken_o=0. Five further not-taken -> counter stays 0.
- Tag mismatch: btb_valid_i=1, btb_tag_i differs from pc_i[31:8], PHT=3 -> pred_taken_o=0, next_pc_o=pc_i+4.
- Target mispredict: upd_taken_i=1, upd_pred_taken_i=1, upd_pred_target_i=0x300, upd_target_i=0x200 -> mispredict_o=1, redirect_pc_o=0x200.
  - Correct not-taken prediction -> mispredict_o=0.
- Reset mid-update: assert rst_i in the cycle after a taken update -> btb_wren_o=0 that cycle and the next; PHT[0] returns to 1.
